// File: rtl/psd_square.sv
// psd_square: iterative shift-add unsigned squarer, one operand bit per clock, start/stop command protocol.
module psd_square #(
    parameter int NUM_BITS = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  stop,
    input  logic [NUM_BITS/2-1:0] xin,
    output logic [NUM_BITS-1:0]   sq,
    output logic                  busy,
    output logic                  done
);
    localparam int HALF = NUM_BITS / 2;
    localparam int CW   = (HALF > 1) ? $clog2(HALF) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t                state_q, state_d;
    logic [HALF-1:0]       x_reg_q, x_reg_d;
    logic [NUM_BITS-1:0]   acc_q, acc_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [NUM_BITS-1:0]   sq_q, sq_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [NUM_BITS-1:0]   addend;
    logic                  last;

    assign addend = {{HALF{1'b0}}, x_reg_q} << cnt_q;
    assign last   = cnt_q == CW'(HALF - 1);

    always_comb begin
        state_d = state_q;
        x_reg_d = x_reg_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = done_q;
        // stop captures the pre-edge accumulator, even when start fires on the same edge
        sq_d    = stop ? acc_q : sq_q;
        if (start) begin
            state_d = RUN;
            x_reg_d = xin;
            acc_d   = '0;
            cnt_d   = '0;
            busy_d  = 1'b1;
            done_d  = 1'b0;
        end else if (state_q == RUN) begin
            acc_d = x_reg_q[cnt_q] ? acc_q + addend : acc_q;
            cnt_d = cnt_q + 1'b1;
            if (last) begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            x_reg_q <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            sq_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_reg_q <= x_reg_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            sq_q    <= sq_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign sq   = sq_q;
    assign busy = busy_q;
    assign done = done_q;
endmodule

// File: tb/tb_psd_square.sv
// tb_psd_square: directed plus randomized checks of psd_square against an arithmetic reference model.
module tb_psd_square;
    localparam int NB = 32;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          stop  = 1'b0;
    logic [15:0]   xin   = '0;
    logic [NB-1:0] sq;
    logic          busy;
    logic          done;

    int n_checks = 0;
    int n_fail   = 0;

    longint unsigned m_x, m_sq;
    int              m_k;
    bit              m_run, m_done;

    psd_square #(.NUM_BITS(NB)) dut (
        .clock(clock), .reset(reset), .start(start), .stop(stop),
        .xin(xin), .sq(sq), .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input longint unsigned got, input longint unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // after k iterations the accumulator holds x * (x mod 2^k)
    function automatic longint unsigned model_acc();
        return m_x * (m_x % (64'd1 << m_k));
    endfunction

    task automatic model_edge();
        if (reset) begin
            m_x = 0; m_k = 0; m_run = 0; m_done = 0; m_sq = 0;
        end else begin
            if (stop) m_sq = model_acc();
            if (start) begin
                m_x = xin; m_k = 0; m_run = 1; m_done = 0;
            end else if (m_run) begin
                m_k++;
                if (m_k == NB / 2) begin
                    m_run = 0; m_done = 1;
                end
            end
        end
    endtask

    task automatic cyc(input logic st, input logic sp, input logic rs, input logic [15:0] x);
        start = st; stop = sp; reset = rs; xin = x;
        @(posedge clock);
        model_edge();
        #1;
        start = 1'b0; stop = 1'b0; reset = 1'b0;
        check("sq", sq, m_sq);
        check("busy", busy, m_run);
        check("done", done, m_done);
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 40) begin
            n++;
            cyc(0, 0, 0, 0);
        end
    endtask

    task automatic square_of(input logic [15:0] x, input longint unsigned exp);
        int n;
        cyc(1, 0, 0, x);
        wait_done(n);
        check("lat", n, 16);
        cyc(0, 1, 0, 0);
        check("sq_full", sq, exp);
    endtask

    initial begin
        int n;
        cyc(0, 0, 1, 0);
        cyc(0, 0, 1, 0);
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0);
        check("rst_sq", sq, 0);
        check("rst_busy", busy, 0);
        square_of(16'd3, 9);
        square_of(16'd0, 0);
        square_of(16'd1, 1);
        square_of(16'd1234, 1522756);
        square_of(16'hFFFF, 64'hFFFE0001);
        cyc(0, 1, 0, 0);
        check("restop", sq, 64'hFFFE0001);
        // partial product after 8 iterations
        cyc(1, 0, 0, 16'hFFFF);
        for (int i = 0; i < 8; i++) cyc(0, 0, 0, 0);
        cyc(0, 1, 0, 0);
        check("partial", sq, 64'h00FEFF01);
        check("partial_busy", busy, 1);
        wait_done(n);
        cyc(0, 1, 0, 0);
        check("after_partial", sq, 64'hFFFE0001);
        // restart mid-operation
        cyc(1, 0, 0, 16'hFFFF);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 16'd7);
        wait_done(n);
        check("restart_lat", n, 16);
        cyc(0, 1, 0, 0);
        check("restart_sq", sq, 49);
        cyc(1, 1, 0, 16'd5);
        check("start_stop_sq", sq, 49);
        check("start_stop_busy", busy, 1);
        wait_done(n);
        cyc(0, 1, 0, 0);
        check("sq5", sq, 25);
        // reset in flight
        cyc(1, 0, 0, 16'd100);
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0);
        cyc(0, 0, 1, 0);
        check("midrst_sq", sq, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        cyc(0, 1, 0, 0);
        check("midrst_stop", sq, 0);
        // randomized traffic
        for (int i = 0; i < 2000; i++)
            cyc($urandom_range(0, 19) == 0, $urandom_range(0, 5) == 0,
                $urandom_range(0, 149) == 0, 16'($urandom));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
